// File: rtl/status_tx_arbiter_if.sv
// Bundle between the status arbiter and its environment: per-channel
// requests and status words in, serializer handshake and grant pulses out.
interface status_tx_arbiter_if;
  logic [3:0]  req;
  logic [95:0] status_in;
  logic        fifo_full;
  logic        piso_done;
  logic [23:0] piso_data;
  logic [7:0]  piso_cmd;
  logic        piso_start;
  logic [3:0]  ack;
  logic        busy;
  logic [7:0]  err_count;

  // Environment side: drives requests and serializer feedback.
  modport master (
    output req, status_in, fifo_full, piso_done,
    input  piso_data, piso_cmd, piso_start, ack, busy, err_count
  );

  // Arbiter side.
  modport slave (
    input  req, status_in, fifo_full, piso_done,
    output piso_data, piso_cmd, piso_start, ack, busy, err_count
  );
endinterface

// File: rtl/status_tx_arbiter.sv
// Round-robin arbiter that picks one of four channels requesting a status
// report, hands its 24-bit status word and a tagged command byte to the
// serializer, then waits for completion or a timeout before arbitrating again.
module status_tx_arbiter #(
  parameter int unsigned TIMEOUT = 1024,
  parameter logic [3:0]  CMD_TAG = 4'hA
) (
  input logic               clk,
  input logic               rst,
  status_tx_arbiter_if.slave bus
);

  localparam int DATA_W = 24;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_WAIT = 2'b10
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [1:0]          ptr_q;
  logic [1:0]          win_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [7:0]          err_q;
  logic [DATA_W-1:0]   data_q;
  logic [7:0]          cmd_q;

  logic [7:0]          req_dbl;
  logic [3:0]          req_rot;
  logic                pick_vld;
  logic [1:0]          pick_off;
  logic [1:0]          pick_idx;
  logic [DATA_W-1:0]   pick_word;
  logic                load_en;
  logic                xfer_end;
  logic                timeout_hit;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Rotate requests so bit 0 is the channel at the round-robin pointer.
  assign req_dbl  = {bus.req, bus.req};
  assign req_rot  = req_dbl[ptr_q +: 4];
  assign pick_vld = |req_rot;
  assign pick_idx = ptr_q + pick_off;

  // First requesting channel at or after the pointer wins.
  always_comb begin
    pick_off = 2'd3;
    if (req_rot[0])      pick_off = 2'd0;
    else if (req_rot[1]) pick_off = 2'd1;
    else if (req_rot[2]) pick_off = 2'd2;
  end

  // Status word of the winning channel.
  always_comb begin
    pick_word = bus.status_in[23:0];
    case (pick_idx)
      2'd1:    pick_word = bus.status_in[47:24];
      2'd2:    pick_word = bus.status_in[71:48];
      2'd3:    pick_word = bus.status_in[95:72];
      default: pick_word = bus.status_in[23:0];
    endcase
  end

  // Next-state decode; done takes precedence over a coincident timeout.
  always_comb begin
    state_d     = S_IDLE;
    load_en     = 1'b0;
    xfer_end    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld && !bus.fifo_full) begin
          state_d = S_LOAD;
          load_en = 1'b1;
        end
      end
      S_LOAD: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.piso_done) begin
          xfer_end = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          xfer_end    = 1'b1;
          timeout_hit = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Winner capture and pointer advance past the channel just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= 2'd0;
      ptr_q <= 2'd0;
    end else begin
      if (load_en)  win_q <= pick_idx;
      if (xfer_end) ptr_q <= win_q + 2'd1;
    end
  end

  // Timeout counter runs only while waiting, zero everywhere else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                cnt_q <= '0;
    else if (state_q == S_WAIT && !xfer_end) cnt_q <= cnt_q + 1'b1;
    else                                    cnt_q <= '0;
  end

  // Saturating count of transfers abandoned by timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              err_q <= 8'd0;
    else if (timeout_hit) err_q <= sat_inc8(err_q);
  end

  // Serializer payload, frozen from the grant until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cmd_q  <= 8'd0;
    end else if (load_en) begin
      data_q <= pick_word;
      cmd_q  <= {CMD_TAG, 2'b00, pick_idx};
    end
  end

  assign bus.piso_data  = data_q;
  assign bus.piso_cmd   = cmd_q;
  assign bus.piso_start = (state_q == S_LOAD);
  assign bus.ack        = (state_q == S_LOAD) ? (4'b0001 << win_q) : 4'b0000;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.err_count  = err_q;

endmodule

// File: tb/tb_status_tx_arbiter.sv
// Bench for status_tx_arbiter: directed vector table, hand-written corner
// sequences, and a randomized run against a transfer-level reference model.
module tb_status_tx_arbiter;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  status_tx_arbiter_if bus ();

  status_tx_arbiter #(.TIMEOUT(TMO), .CMD_TAG(4'hA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (bus.piso_start === 1'b1) ok = 1'b1;
      else step();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_start: no piso_start within %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 4'd0;
    bus.status_in = '0;
    bus.fifo_full = 1'b0;
    bus.piso_done = 1'b0;
    step();
    step();
    chk("reset_outputs",
        {bus.busy, bus.piso_start, bus.ack, bus.piso_data, bus.piso_cmd, bus.err_count}, '0);
    rst = 1'b0;
  endtask

  // ---------------- transfer-level reference model ----------------
  // A transfer has an age counted from its start cycle (age 0 = grant
  // cycle). Done is honoured from age 1; the transfer is abandoned once it
  // has been waiting TMO cycles.
  bit          m_active;
  int          m_age;
  int          m_chan;
  int          m_ptr;
  int          m_err;
  logic [23:0] m_data;
  logic [7:0]  m_cmd;

  function automatic void m_reset();
    m_active = 0; m_age = 0; m_chan = 0; m_ptr = 0; m_err = 0;
    m_data = '0; m_cmd = '0;
  endfunction

  function automatic logic [45:0] m_expect();
    logic       st;
    logic [3:0] ak;
    st = m_active && (m_age == 0);
    ak = st ? (4'b0001 << m_chan) : 4'b0000;
    return {m_active, st, ak, m_data, m_cmd, 8'(m_err)};
  endfunction

  function automatic void m_advance(input logic [3:0] r, input logic f,
                                    input logic d, input logic [95:0] s);
    bit found;
    if (m_active) begin
      if (m_age >= 1 && d) begin
        m_active = 0;
        m_ptr = (m_chan + 1) % 4;
      end else if (m_age == TMO) begin
        m_active = 0;
        m_ptr = (m_chan + 1) % 4;
        if (m_err < 255) m_err++;
      end else begin
        m_age++;
      end
    end else if (r != 4'd0 && !f) begin
      found = 0;
      for (int i = 0; i < 4; i++) begin
        if (!found && r[(m_ptr + i) % 4]) begin
          m_chan = (m_ptr + i) % 4;
          found = 1;
        end
      end
      m_active = 1;
      m_age = 0;
      m_data = s[m_chan*24 +: 24];
      m_cmd = {4'hA, 2'b00, 2'(m_chan)};
    end
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]  req;
    logic        full;
    logic [95:0] stat;
    logic        exp_start;
    logic [3:0]  exp_ack;
    logic [23:0] exp_data;
    logic [7:0]  exp_cmd;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit ok;
    int last_done;
    int s;
    int nt;
    logic [3:0]  rq;
    logic        ff;
    logic        dn;
    logic [95:0] st;

    bus.req = 4'd0;
    bus.status_in = '0;
    bus.fifo_full = 1'b0;
    bus.piso_done = 1'b0;

    // Pointer starts at 0 after reset and advances past each winner.
    tbl[0] = '{4'b0100, 1'b0, {24'hAAAAAA, 24'h123456, 24'h111111, 24'h000001},
               1'b1, 4'b0100, 24'h123456, 8'hA2};
    tbl[1] = '{4'b1111, 1'b0, {24'hFEDCBA, 24'h222222, 24'h333333, 24'h444444},
               1'b1, 4'b1000, 24'hFEDCBA, 8'hA3};
    tbl[2] = '{4'b0110, 1'b0, {24'h000000, 24'h000000, 24'h5A5A5A, 24'h000000},
               1'b1, 4'b0010, 24'h5A5A5A, 8'hA1};
    tbl[3] = '{4'b0011, 1'b0, {24'h000001, 24'h000002, 24'h000003, 24'hC0FFEE},
               1'b1, 4'b0001, 24'hC0FFEE, 8'hA0};
    tbl[4] = '{4'b0001, 1'b1, {24'h999999, 24'h888888, 24'h777777, 24'h666666},
               1'b0, 4'b0000, 24'hC0FFEE, 8'hA0};
    tbl[5] = '{4'b1001, 1'b0, {24'h765432, 24'h000000, 24'h000000, 24'h000000},
               1'b1, 4'b1000, 24'h765432, 8'hA3};

    do_reset();

    for (int k = 0; k < 6; k++) begin
      bus.req = tbl[k].req;
      bus.fifo_full = tbl[k].full;
      bus.status_in = tbl[k].stat;
      step();
      chk($sformatf("vec%0d_start", k), bus.piso_start, tbl[k].exp_start);
      chk($sformatf("vec%0d_ack", k), bus.ack, tbl[k].exp_ack);
      chk($sformatf("vec%0d_busy", k), bus.busy, tbl[k].exp_start);
      chk($sformatf("vec%0d_data", k), bus.piso_data, tbl[k].exp_data);
      chk($sformatf("vec%0d_cmd", k), bus.piso_cmd, tbl[k].exp_cmd);
      bus.req = 4'd0;
      bus.fifo_full = 1'b0;
      if (tbl[k].exp_start) begin
        bus.status_in = {$urandom, $urandom, $urandom};
        step();
        chk($sformatf("vec%0d_hold", k), {bus.piso_data, bus.piso_cmd, bus.ack, bus.piso_start},
            {tbl[k].exp_data, tbl[k].exp_cmd, 4'b0000, 1'b0});
        bus.piso_done = 1'b1;
        step();
        bus.piso_done = 1'b0;
        chk($sformatf("vec%0d_idle", k), bus.busy, 1'b0);
      end else begin
        step();
      end
    end

    // Round-robin with all channels held, done 5 cycles after each start.
    do_reset();
    bus.req = 4'hF;
    last_done = 0;
    for (int k = 0; k < 5; k++) begin
      wait_start(20, ok);
      chk($sformatf("rr_ack%0d", k), bus.ack, 4'b0001 << (k % 4));
      if (k > 0) chk($sformatf("rr_gap%0d", k), cyc - last_done, 2);
      s = cyc;
      repeat (5) step();
      bus.piso_done = 1'b1;
      last_done = cyc;
      step();
      bus.piso_done = 1'b0;
      if (k == 4) bus.req = 4'd0;
    end
    step();
    chk("rr_end_idle", bus.busy, 1'b0);

    // fifo_full holds off arbitration; start follows its release.
    do_reset();
    bus.req = 4'b0001;
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("full_block%0d", i), {bus.busy, bus.piso_start, bus.ack}, 6'd0);
    end
    bus.fifo_full = 1'b0;
    step();
    chk("full_release", {bus.piso_start, bus.ack}, {1'b1, 4'b0001});
    bus.req = 4'd0;
    step();
    bus.piso_done = 1'b1;
    step();
    bus.piso_done = 1'b0;
    step();

    // Repeated timeouts: busy lasts 16 cycles past the grant, counter saturates.
    do_reset();
    bus.req = 4'b0001;
    for (int t = 1; t <= 300; t++) begin
      wait_start(40, ok);
      if (!ok) break;
      repeat (TMO) step();
      chk($sformatf("tmo%0d_busy_hi", t), bus.busy, 1'b1);
      step();
      chk($sformatf("tmo%0d_busy_lo", t), bus.busy, 1'b0);
      chk($sformatf("tmo%0d_err", t), bus.err_count, (t > 255) ? 255 : t);
    end
    bus.req = 4'd0;
    step();

    // Asynchronous reset in the middle of a wait.
    bus.req = 4'b0010;
    wait_start(20, ok);
    bus.req = 4'd0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs",
        {bus.busy, bus.piso_start, bus.ack, bus.piso_data, bus.piso_cmd, bus.err_count}, '0);
    #1 rst = 1'b0;
    bus.req = 4'b1000;
    step();
    chk("post_rst_grant", {bus.piso_start, bus.ack}, {1'b1, 4'b1000});
    bus.req = 4'd0;
    step();
    bus.piso_done = 1'b1;
    step();
    bus.piso_done = 1'b0;
    bus.req = 4'b1001;
    step();
    chk("post_rst_ptr", bus.ack, 4'b0001);
    bus.req = 4'd0;
    step();
    bus.piso_done = 1'b1;
    step();
    bus.piso_done = 1'b0;

    // Done during the grant cycle is ignored.
    bus.req = 4'b0001;
    wait_start(20, ok);
    bus.piso_done = 1'b1;
    bus.req = 4'd0;
    step();
    bus.piso_done = 1'b0;
    chk("done_in_load_wait", bus.busy, 1'b1);
    repeat (3) step();
    chk("done_in_load_still", bus.busy, 1'b1);
    bus.piso_done = 1'b1;
    step();
    bus.piso_done = 1'b0;
    chk("done_in_load_end", bus.busy, 1'b0);

    // Randomized run against the reference model.
    do_reset();
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      chk($sformatf("rand%0d {busy,start,ack,data,cmd,err}", i),
          {bus.busy, bus.piso_start, bus.ack, bus.piso_data, bus.piso_cmd, bus.err_count},
          m_expect());
      rq = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
      ff = ($urandom_range(0, 3) == 0);
      dn = ($urandom_range(0, 11) == 0);
      st = {$urandom, $urandom, $urandom};
      bus.req = rq;
      bus.fifo_full = ff;
      bus.piso_done = dn;
      bus.status_in = st;
      m_advance(rq, ff, dn, st);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/status_tx_arbiter.md
STATUS_TX_ARBITER -- requirements
Module: status_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024: maximum WAIT cycles before a transfer is aborted.
REQ-002 Parameter CMD_TAG, default 4'hA: upper nibble of every emitted command byte.
REQ-003 clk  in  1  single clock for the block; all flops rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req  in  4  per-channel status-report request, level, held until ack.
REQ-006 status_in  in  96  channel n status word at bits [24n+23:24n].
REQ-007 fifo_full  in  1  output FIFO full; blocks new arbitration.
REQ-008 piso_done  in  1  one-cycle pulse from serializer, transfer complete.
REQ-009 piso_data  out  24  registered status word for serializer.
REQ-010 piso_cmd  out  8  registered command byte {CMD_TAG, 2'b00, channel index}.
REQ-011 piso_start  out  1  one-cycle start pulse to serializer.
REQ-012 ack  out  4  one-hot one-cycle grant pulse to the winning channel.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 err_count  out  8  saturating count of timed-out transfers.

Function
REQ-015 FSM states IDLE, LOAD, WAIT; encoding is free; illegal states SHALL return to IDLE.
REQ-016 IDLE: if (req != 0) and fifo_full == 0, winner SHALL be chosen round-robin, starting at pointer ptr (2 bits) and scanning ptr, ptr+1, ... mod 4; go to LOAD.
REQ-017 On the IDLE->LOAD edge, winner index, status word and command byte SHALL be latched into piso_data/piso_cmd; later req/status_in changes do not alter them.
REQ-018 LOAD (exactly one cycle): piso_start=1 and ack[winner]=1; go to WAIT; timeout counter cleared.
REQ-019 Latency: req rising in IDLE at cycle N (fifo_full low) -> piso_start and ack at cycle N+1.
REQ-020 WAIT: piso_done=1 -> IDLE, ptr <= winner+1 mod 4.
REQ-021 WAIT: counter increments each cycle; when counter reaches TIMEOUT-1 without piso_done, go to IDLE, ptr <= winner+1, err_count += 1, saturating at 8'hFF.
REQ-022 piso_done and timeout in the same cycle: treated as done, err_count unchanged.
REQ-023 piso_done outside WAIT (including during LOAD) SHALL be ignored.
REQ-024 fifo_full only gates the IDLE decision; it has no effect in LOAD or WAIT.
REQ-025 Back-to-back: with req held, the next LOAD SHALL follow IDLE by one cycle; minimum transfer period is done-cycle + 2.
REQ-026 ack and piso_start are never high outside LOAD; ack is zero or one-hot.
REQ-027 piso_data/piso_cmd hold their value until the next LOAD latch.

Reset
REQ-028 rst high SHALL immediately force state IDLE, ptr 0, timeout counter 0, err_count 0, piso_data 0, piso_cmd 0, piso_start 0, ack 0, busy 0.
REQ-029 rst asserted mid-transfer aborts it with no ack/start pulse.
REQ-030 After release, arbitration resumes from channel 0 on the first clk edge with rst low.

Verification
REQ-031 req=4'b0100, status ch2=24'h123456, fifo_full=0 -> next cycle piso_start=1, ack=4'b0100, piso_data=24'h123456, piso_cmd=8'hA2.
REQ-032 req=4'b1111 held, piso_done returned 5 cycles after each start -> ack sequence ch0,ch1,ch2,ch3,ch0; each start is 2 cycles after the preceding done.
REQ-033 req=4'b0001, fifo_full=1 for 10 cycles -> no start/ack and busy=0; fifo_full falls -> start on the next cycle.
REQ-034 TIMEOUT=16, no piso_done -> busy drops 16 cycles after LOAD, err_count=1; repeat 300 times -> err_count=8'hFF.
REQ-035 rst pulsed during WAIT -> all outputs zero asynchronously; after release with req=4'b1000 -> ack=4'b1000 and ptr advances to 0.
REQ-036 piso_done pulsed during LOAD -> ignored; FSM stays in WAIT until a later done pulse.
